// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: block type, forward S-box, round constants and
// small byte/word helpers used by the iterative encryptor.
package aes_pkg;

  localparam int NUM_ROUNDS = 10;

  typedef logic [127:0] block_t;

  localparam logic [0:255][7:0] SBOX = {
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Indexed directly by the 4-bit round number; entry 0 and 11..15 are unused.
  localparam logic [0:15][7:0] RCON = {
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
    8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes128_encrypt_iter_encryption_round.sv
// One combinational AES forward round: SubBytes, ShiftRows, MixColumns
// (skipped when final_round is set) and AddRoundKey.
module encryption_round
  import aes_pkg::*;
(
  input  block_t state,
  input  block_t round_key,
  input  logic   final_round,
  output block_t next_state
);

  // Byte i sits at bits [127-8i -: 8]; byte i is row i%4 of column i/4.
  function automatic block_t sub_shift(input block_t s);
    block_t o;
    o = '0;
    for (int i = 0; i < 16; i++) begin
      o[127-8*i -: 8] = sbox(s[127-8*((i%4) + 4*(((i/4) + (i%4)) % 4)) -: 8]);
    end
    return o;
  endfunction

  function automatic block_t mix_columns(input block_t s);
    block_t     o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                           a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                           a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                           xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    end
    return o;
  endfunction

  block_t shifted;

  assign shifted    = sub_shift(state);
  assign next_state = (final_round ? shifted : mix_columns(shifted)) ^ round_key;

endmodule

// File: rtl/aes128_encrypt_iter.sv
// Iterative AES-128 encryptor: one round per clock, key schedule on the fly.
// Define AES_ENC_LAST_KEY_EN to expose the round-10 key on last_key.
module aes128_encrypt_iter
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] key,
  input  logic [127:0] plaintext,
  output logic         busy,
  output logic         done,
  output logic [127:0] ciphertext
`ifdef AES_ENC_LAST_KEY_EN
  ,
  output logic [127:0] last_key
`endif
);

  typedef enum logic {IDLE, RUN} fsm_t;

  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

  fsm_t       fsm;
  logic [3:0] round_q;
  block_t     state_q;
  block_t     key_q;
  block_t     round_key;
  block_t     next_state;
  logic       accept;

  function automatic block_t next_round_key(input block_t k, input logic [3:0] r);
    logic [31:0] t, w0, w1, w2, w3;
    t  = sub_word({k[23:0], k[31:24]}) ^ {RCON[r], 24'h0};
    w0 = k[127:96] ^ t;
    w1 = k[95:64]  ^ w0;
    w2 = k[63:32]  ^ w1;
    w3 = k[31:0]   ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  assign accept    = start && (fsm == IDLE);
  assign busy      = (fsm == RUN);
  assign round_key = next_round_key(key_q, round_q);

  encryption_round u_round (
    .state       (state_q),
    .round_key   (round_key),
    .final_round (round_q == LAST_ROUND),
    .next_state  (next_state)
  );

  // NOTE: state/key registers carry no reset; they are always reloaded on acceptance before use.
  always_ff @(posedge clk) begin
    if (accept) begin
      state_q <= plaintext ^ key;
      key_q   <= key;
    end else if (fsm == RUN) begin
      state_q <= next_state;
      key_q   <= round_key;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm        <= IDLE;
      round_q    <= '0;
      done       <= 1'b0;
      ciphertext <= '0;
`ifdef AES_ENC_LAST_KEY_EN
      last_key   <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (fsm)
        IDLE: begin
          if (start) begin
            fsm     <= RUN;
            round_q <= 4'd1;
          end
        end
        RUN: begin
          if (round_q == LAST_ROUND) begin
            fsm        <= IDLE;
            done       <= 1'b1;
            ciphertext <= next_state;
`ifdef AES_ENC_LAST_KEY_EN
            last_key   <= round_key;
`endif
          end else begin
            round_q <= round_q + 4'd1;
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes128_encrypt_iter.sv
// Scoreboard bench for aes128_encrypt_iter: FIPS-197 vectors, busy/back-to-back
// protocol, mid-block reset and random blocks against a byte-level AES model.
module tb_aes128_encrypt_iter;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [127:0] key = '0;
  logic [127:0] plaintext = '0;
  logic         busy;
  logic         done;
  logic [127:0] ciphertext;
`ifdef AES_ENC_LAST_KEY_EN
  logic [127:0] last_key;
`endif

  aes128_encrypt_iter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .key        (key),
    .plaintext  (plaintext),
    .busy       (busy),
    .done       (done),
    .ciphertext (ciphertext)
`ifdef AES_ENC_LAST_KEY_EN
    ,
    .last_key   (last_key)
`endif
  );

  always #5 clk = ~clk;

  localparam logic [127:0] KB = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PB = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CB = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] LB = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] KC = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PC = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CC = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] LC = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  typedef struct {
    logic [127:0] ct;
    logic [127:0] lk;
    int           acc;
  } exp_t;

  exp_t         sb[$];
  exp_t         mon_e;
  logic [127:0] last_ct = '0;
  int           cyc = 0;
  int           next_free = 0;
  int           checks = 0;
  int           errors = 0;
  logic [7:0]   sb_tab[256];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model: AES from GF(2^8) arithmetic ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb_tab[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic ref_aes(input logic [127:0] k, input logic [127:0] p,
                         output logic [127:0] ct, output logic [127:0] lk);
    logic [31:0] w[44];
    logic [31:0] tmp;
    logic [7:0]  s[16];
    logic [7:0]  t[16];
    logic [7:0]  rc, a0, a1, a2, a3;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sb_tab[tmp[31:24]], sb_tab[tmp[23:16]], sb_tab[tmp[15:8]], sb_tab[tmp[7:0]]} ^ {rc, 24'h0};
        rc  = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = p[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sb_tab[s[(i%4) + 4*(((i/4) + (i%4)) % 4)]];
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        if (r < 10) begin
          s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end else begin
          s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r + i/4][31-8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) ct[127-8*i -: 8] = s[i];
    lk = {w[40], w[41], w[42], w[43]};
  endtask

  // ---------------- monitor: pops the scoreboard on every done ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      last_ct = '0;
    end else begin
      check("done_busy_exclusive", 128'(done & busy), 128'(0));
      if (done) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1 expected no pending block (cycle %0d)", cyc);
        end else begin
          mon_e = sb.pop_front();
          check("ciphertext", ciphertext, mon_e.ct);
          check("latency", 128'(cyc), 128'(mon_e.acc + 10));
`ifdef AES_ENC_LAST_KEY_EN
          check("last_key", last_key, mon_e.lk);
`endif
        end
        last_ct = ciphertext;
      end else begin
        check("ct_hold", ciphertext, last_ct);
      end
    end
  end

  // ---------------- driver ----------------
  // Called just after a negedge; returns at the following negedge.
  task automatic issue(input logic [127:0] k, input logic [127:0] p,
                       input logic [127:0] ct, input logic [127:0] lk);
    bit acc_ok;
    acc_ok = (cyc + 1 >= next_free);
    check("busy_at_start", 128'(busy), 128'(!acc_ok));
    start     = 1'b1;
    key       = k;
    plaintext = p;
    @(posedge clk);
    #1;
    start     = 1'b0;
    key       = {$urandom, $urandom, $urandom, $urandom};
    plaintext = {$urandom, $urandom, $urandom, $urandom};
    if (acc_ok) begin
      sb.push_back('{ct: ct, lk: lk, acc: cyc});
      next_free = cyc + 11;
    end
    @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
    check("drain", 128'(sb.size()), 128'(0));
    @(negedge clk);
  endtask

  task automatic wait_done();
    int i;
    for (i = 0; i < 20 && !done; i++) @(negedge clk);
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done expected done within 20 cycles");
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no end expected finish before 500000");
    $fatal(1);
  end

  initial begin
    logic [127:0] rk, rp, rct, rlk;
    build_sbox();
    repeat (2) @(negedge clk);
    check("reset_busy", 128'(busy), 128'(0));
    check("reset_done", 128'(done), 128'(0));
    check("reset_ct", ciphertext, '0);
`ifdef AES_ENC_LAST_KEY_EN
    check("reset_last_key", last_key, '0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    issue(KB, PB, CB, LB);
    drain();
    issue(KC, PC, CC, LC);
    drain();

    // start while busy must be ignored
    issue(KB, PB, CB, LB);
    repeat (4) @(negedge clk);
    issue(KC, PC, CC, LC);
    drain();

    // start in the done cycle is accepted
    issue(KB, PB, CB, LB);
    wait_done();
    issue(KC, PC, CC, LC);
    drain();

    // reset mid-block: aborted, asynchronous clear, next block clean
    issue(KB, PB, CB, LB);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_busy", 128'(busy), 128'(0));
    check("async_reset_ct", ciphertext, '0);
    check("async_reset_done", 128'(done), 128'(0));
    sb.delete();
    next_free = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    issue(KC, PC, CC, LC);
    drain();

    // random blocks with random spacing and stray starts while busy
    for (int n = 0; n < 12; n++) begin
      rk = {$urandom, $urandom, $urandom, $urandom};
      rp = {$urandom, $urandom, $urandom, $urandom};
      ref_aes(rk, rp, rct, rlk);
      issue(rk, rp, rct, rlk);
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(0, 6)) @(negedge clk);
        rk = {$urandom, $urandom, $urandom, $urandom};
        rp = {$urandom, $urandom, $urandom, $urandom};
        ref_aes(rk, rp, rct, rlk);
        issue(rk, rp, rct, rlk);
      end
      for (int i = 0; i < 30 && (cyc + 1 < next_free); i++) @(negedge clk);
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
